write_back_arbiter: RTL and testbench
=====================================

WRITE_BACK_ARBITER -- requirements
Module: write_back_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, auxiliary write-request buffer entries (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive blocked cycles before the guard forces an auxiliary drain (1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESETN  input  1  asynchronous active-low reset.
REQ-006 PIPE_RD_ADDRESS_IN  input  5  write-back stage destination register.
REQ-007 PIPE_RD_DATA_IN  input  32  write-back stage result (mux output).
REQ-008 PIPE_RD_WRITE_ENABLE_IN  input  1  write-back stage write request.
REQ-009 AUX_VALID  input  1  long-latency unit (mul/div, miss refill) write request.
REQ-010 AUX_RD_ADDRESS  input  5  auxiliary destination register.
REQ-011 AUX_RD_DATA  input  32  auxiliary result.
REQ-012 AUX_READY  output  1  buffer can accept; transfer when AUX_VALID and AUX_READY both high.
REQ-013 RD_ADDRESS_OUT  output  5  register-file write address.
REQ-014 RD_DATA_OUT  output  32  register-file write data.
REQ-015 RD_WRITE_ENABLE_OUT  output  1  register-file write strobe.
REQ-016 PIPE_STALL  output  1  pipeline SHALL hold write-back inputs stable while high.
REQ-017 AUX_PENDING  output  1  buffer non-empty; used by the hazard unit.

Function
REQ-018 RD_* outputs SHALL be registered: a grant at edge N appears on RD_* after edge N, one cycle latency.
REQ-019 A request with address 5'd0 (pipe or aux) SHALL never produce RD_WRITE_ENABLE_OUT; aux x0 entries are still accepted and popped.
REQ-020 Auxiliary requests SHALL enter a FIFO of FIFO_DEPTH entries; AUX_READY = not full (no same-cycle pop credit).
REQ-021 Arbitration per cycle: pipe request (enable=1, rd!=0) wins unless state is GUARD; otherwise the FIFO head is popped and written if non-empty; otherwise RD_WRITE_ENABLE_OUT=0.
REQ-022 Simultaneous push and pop SHALL both occur; occupancy unchanged; pop of the only entry while pushing SHALL write the old head.
REQ-023 Push into an empty FIFO SHALL not be eligible for pop in the same cycle (head visible next cycle).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-025 Starvation counter (8 bits) SHALL increment each cycle the FIFO is non-empty and no pop occurs, clear on any pop or when empty, and saturate at STARVE_LIMIT.
REQ-026 States: NORMAL (pipe priority) and GUARD (aux priority); NORMAL->GUARD when counter reaches STARVE_LIMIT; GUARD->NORMAL after exactly one pop.
REQ-027 PIPE_STALL SHALL equal (state==GUARD) combinationally; pipe request is ignored, not lost, in GUARD.
REQ-028 Ordering between pipe and aux writes to the same register is the hazard unit's responsibility via AUX_PENDING; the block SHALL not reorder within the FIFO.

Reset
REQ-029 On RESETN low, immediately: RD_WRITE_ENABLE_OUT=0, RD_ADDRESS_OUT=0, RD_DATA_OUT=0, FIFO empty, AUX_READY=1, AUX_PENDING=0, counter=0, state NORMAL, PIPE_STALL=0.
REQ-030 Reset mid-operation SHALL discard all buffered aux entries; release is synchronous to the next CLK edge.

Configuration
REQ-031 Macro WRITE_BACK_ARBITER_STARVE_GUARD_EN: defined -> counter and GUARD state per REQ-025..027; undefined -> no counter, state fixed NORMAL, PIPE_STALL tied 0, aux drains only on pipe-idle cycles.

Verification
REQ-032 Pipe write rd=5, data=0xDEADBEEF, no aux -> next cycle RD_WRITE_ENABLE_OUT=1, RD_ADDRESS_OUT=5, RD_DATA_OUT=0xDEADBEEF.
REQ-033 Pipe write rd=0 data=0x1234 -> RD_WRITE_ENABLE_OUT stays 0.
REQ-034 Push 4 aux entries (rd 1..4) while pipe writes every cycle -> AUX_READY=0 after fourth push; pipe idle -> rd 1,2,3,4 written in order, AUX_PENDING falls after last.
REQ-035 Guard enabled, STARVE_LIMIT=8, one aux entry, pipe writes continuously -> PIPE_STALL=1 for one cycle after 8 blocked cycles, aux entry written, then held pipe write written next.
REQ-036 Guard disabled, same stimulus -> PIPE_STALL never asserts; aux entry written on first pipe-idle cycle.
REQ-037 Assert RESETN low with 3 entries buffered mid-drain -> outputs zero immediately, AUX_READY=1, no buffered write appears after release.

Source files
------------

// File: rtl/write_back_arbiter.sv
// ---------------------------------------------------------------------------
// write_back_arbiter
//
// Merges two register-file write sources onto one write port:
//   * the pipeline write-back stage (single-cycle results), and
//   * long-latency units (mul/div, miss refill), which are buffered in a
//     small FIFO.
// The pipe normally has priority and aux entries drain on idle cycles.
//
// Optional feature (macro WRITE_BACK_ARBITER_STARVE_GUARD_EN):
//   defined   -> a starvation counter tracks cycles in which the FIFO head
//                is blocked. When it reaches STARVE_LIMIT the block enters
//                GUARD. GUARD stalls the pipe for one cycle and drains one
//                aux entry.
//   undefined -> no counter and no GUARD state. PIPE_STALL is tied low and
//                aux entries drain only on pipe-idle cycles.
//
// Parameters
//   FIFO_DEPTH   aux buffer entries (power of two, 2..16)
//   STARVE_LIMIT blocked cycles before a forced aux drain (1..255)
//
// Ports
//   CLK, RESETN                 clock, asynchronous active-low reset
//   PIPE_RD_ADDRESS_IN/DATA_IN  write-back destination register and result
//   PIPE_RD_WRITE_ENABLE_IN     write-back write request
//   AUX_VALID/RD_ADDRESS/DATA   aux write request (valid/ready handshake)
//   AUX_READY                   buffer not full
//   RD_ADDRESS_OUT/DATA_OUT     registered register-file write port
//   RD_WRITE_ENABLE_OUT         registered register-file write strobe
//   PIPE_STALL                  pipe must hold its write-back inputs
//   AUX_PENDING                 buffer non-empty (consumed by hazard unit)
// ---------------------------------------------------------------------------
module write_back_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [4:0]  PIPE_RD_ADDRESS_IN,
  input  logic [31:0] PIPE_RD_DATA_IN,
  input  logic        PIPE_RD_WRITE_ENABLE_IN,
  input  logic        AUX_VALID,
  input  logic [4:0]  AUX_RD_ADDRESS,
  input  logic [31:0] AUX_RD_DATA,
  output logic        AUX_READY,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RD_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        PIPE_STALL,
  output logic        AUX_PENDING
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  // Elaboration-time range checks on the parameters.
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  // Aux FIFO storage. It is not reset: the pointers and count define validity.
  logic [4:0]    addr_mem [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic        fifo_nonempty;
  logic        push, pop;
  logic        pipe_req, pipe_grant;
  logic        guard_active;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  logic        rd_we_reg;
  logic [4:0]  rd_addr_reg;
  logic [31:0] rd_data_reg;

  assign fifo_nonempty = (count_reg != '0);
  assign AUX_READY     = (count_reg != FULL_COUNT);
  assign AUX_PENDING   = fifo_nonempty;
  assign push          = AUX_VALID && AUX_READY;
  assign head_addr     = addr_mem[rd_ptr_reg];
  assign head_data     = data_mem[rd_ptr_reg];

  // A pipe request to x0 is not a real request, so the aux head may use the slot.
  assign pipe_req   = PIPE_RD_WRITE_ENABLE_IN && (PIPE_RD_ADDRESS_IN != 5'd0);
  assign pipe_grant = pipe_req && !guard_active;
  // fifo_nonempty comes from registered state, so an entry pushed into an
  // empty FIFO is not eligible to pop until the next cycle.
  assign pop        = fifo_nonempty && (guard_active || !pipe_req);

`ifdef WRITE_BACK_ARBITER_STARVE_GUARD_EN
  typedef enum logic {ST_NORMAL, ST_GUARD} state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state_reg, state_next;
  logic [7:0] starve_reg, starve_next;

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    if (!fifo_nonempty || pop) begin
      starve_next = 8'd0;
    end else if (starve_reg < LIMIT) begin
      starve_next = starve_reg + 8'd1;
    end
    case (state_reg)
      ST_NORMAL: if (starve_next == LIMIT) state_next = ST_GUARD;
      // GUARD always pops when the FIFO holds data. The empty check only
      // keeps the FSM from sticking in GUARD.
      ST_GUARD:  if (pop || !fifo_nonempty) state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg  <= ST_NORMAL;
      starve_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  assign guard_active = (state_reg == ST_GUARD);
`else
  assign guard_active = 1'b0;
`endif

  assign PIPE_STALL = guard_active;

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= AUX_RD_ADDRESS;
      data_mem[wr_ptr_reg] <= AUX_RD_DATA;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered write port. An x0 aux entry is popped but never strobed.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_we_reg   <= 1'b0;
      rd_addr_reg <= 5'd0;
      rd_data_reg <= 32'd0;
    end else if (pipe_grant) begin
      rd_we_reg   <= 1'b1;
      rd_addr_reg <= PIPE_RD_ADDRESS_IN;
      rd_data_reg <= PIPE_RD_DATA_IN;
    end else if (pop) begin
      rd_we_reg   <= (head_addr != 5'd0);
      rd_addr_reg <= head_addr;
      rd_data_reg <= head_data;
    end else begin
      rd_we_reg   <= 1'b0;
    end
  end

  assign RD_WRITE_ENABLE_OUT = rd_we_reg;
  assign RD_ADDRESS_OUT      = rd_addr_reg;
  assign RD_DATA_OUT         = rd_data_reg;

endmodule

// File: tb/tb_write_back_arbiter.sv
module tb_write_back_arbiter;

  logic        clk;
  logic        resetn;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_we;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        pipe_stall;
  logic        aux_pending;

  int checks = 0;
  int errors = 0;

  write_back_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(clk),
    .RESETN(resetn),
    .PIPE_RD_ADDRESS_IN(pipe_addr),
    .PIPE_RD_DATA_IN(pipe_data),
    .PIPE_RD_WRITE_ENABLE_IN(pipe_we),
    .AUX_VALID(aux_valid),
    .AUX_RD_ADDRESS(aux_addr),
    .AUX_RD_DATA(aux_data),
    .AUX_READY(aux_ready),
    .RD_ADDRESS_OUT(rd_addr),
    .RD_DATA_OUT(rd_data),
    .RD_WRITE_ENABLE_OUT(rd_we),
    .PIPE_STALL(pipe_stall),
    .AUX_PENDING(aux_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t we=%0b addr=%0d data=%08h ready=%0b pending=%0b stall=%0b",
             $time, rd_we, rd_addr, rd_data, aux_ready, aux_pending, pipe_stall);
  endtask

  task automatic set_pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_we = en; pipe_addr = a; pipe_data = d;
  endtask

  task automatic set_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
    aux_valid = v; aux_addr = a; aux_data = d;
  endtask

  task automatic test_reset();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_aux(1'b0, 5'd0, 32'd0);
    resetn = 1'b0;
    #2;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rd_we); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data got %08h exp 0", rd_data); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", aux_ready); end
    checks++; if (aux_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b exp 0", aux_pending); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", pipe_stall); end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL idle_we got %0b exp 0", rd_we); end
  endtask

  task automatic test_pipe_write();
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL pipe_we got %0b exp 1", rd_we); end
    checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL pipe_addr got %0d exp 5", rd_addr); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_data got %08h exp deadbeef", rd_data); end
    set_pipe(1'b1, 5'd0, 32'h1234);
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL pipe_x0_we got %0b exp 0", rd_we); end
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
  endtask

  // Fill the FIFO while the pipe owns the port, then drain it in order.
  task automatic test_fifo_fill_drain();
    for (int i = 0; i < 4; i++) begin
      checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %0b exp 1", i, aux_ready); end
      set_pipe(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      set_aux(1'b1, 5'(1 + i), 32'hA0 + 32'(i));
      tick();
      checks++; if (rd_we !== 1'b1 || rd_addr !== 5'(10 + i) || rd_data !== 32'h100 + 32'(i))
        begin errors++; $display("FAIL fill_pipe%0d got we=%0b a=%0d d=%08h exp we=1 a=%0d", i, rd_we, rd_addr, rd_data, 10 + i); end
    end
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", aux_ready); end
    checks++; if (aux_pending !== 1'b1) begin errors++; $display("FAIL full_pending got %0b exp 1", aux_pending); end
    set_aux(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_we !== 1'b1 || rd_addr !== 5'(1 + i) || rd_data !== 32'hA0 + 32'(i))
        begin errors++; $display("FAIL drain%0d got we=%0b a=%0d d=%08h exp we=1 a=%0d d=%08h", i, rd_we, rd_addr, rd_data, 1 + i, 32'hA0 + 32'(i)); end
      if (i < 3) begin
        checks++; if (aux_pending !== 1'b1) begin errors++; $display("FAIL drain_pending%0d got %0b exp 1", i, aux_pending); end
      end
    end
    checks++; if (aux_pending !== 1'b0) begin errors++; $display("FAIL drained_pending got %0b exp 0", aux_pending); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL drained_ready got %0b exp 1", aux_ready); end
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL drained_we got %0b exp 0", rd_we); end
  endtask

  // x0 aux entry is accepted and popped but never strobed.
  task automatic test_aux_x0();
    set_aux(1'b1, 5'd0, 32'h5555);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    checks++; if (aux_pending !== 1'b1) begin errors++; $display("FAIL x0_pending got %0b exp 1", aux_pending); end
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL x0_push_we got %0b exp 0", rd_we); end
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL x0_pop_we got %0b exp 0", rd_we); end
    checks++; if (aux_pending !== 1'b0) begin errors++; $display("FAIL x0_popped_pending got %0b exp 0", aux_pending); end
  endtask

  // Push into empty is not visible the same cycle; push+pop keeps occupancy.
  task automatic test_back_to_back();
    set_aux(1'b1, 5'd7, 32'h77);
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL b2b_first_we got %0b exp 0", rd_we); end
    set_aux(1'b1, 5'd8, 32'h88);
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77)
      begin errors++; $display("FAIL b2b_old_head got we=%0b a=%0d d=%08h exp we=1 a=7 d=77", rd_we, rd_addr, rd_data); end
    checks++; if (aux_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got %0b exp 1", aux_pending); end
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd8 || rd_data !== 32'h88)
      begin errors++; $display("FAIL b2b_second got we=%0b a=%0d d=%08h exp we=1 a=8 d=88", rd_we, rd_addr, rd_data); end
    checks++; if (aux_pending !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", aux_pending); end
    tick();
  endtask

  task automatic test_starve();
    set_pipe(1'b1, 5'd9, 32'h99);
    set_aux(1'b1, 5'd3, 32'h33);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd9) begin errors++; $display("FAIL starve_push got we=%0b a=%0d exp we=1 a=9", rd_we, rd_addr); end
`ifdef WRITE_BACK_ARBITER_STARVE_GUARD_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd9) begin errors++; $display("FAIL starve_blk%0d got we=%0b a=%0d exp we=1 a=9", k, rd_we, rd_addr); end
      checks++; if (pipe_stall !== (k == 8)) begin errors++; $display("FAIL starve_stall%0d got %0b exp %0b", k, pipe_stall, k == 8); end
    end
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h33)
      begin errors++; $display("FAIL guard_aux got we=%0b a=%0d d=%08h exp we=1 a=3 d=33", rd_we, rd_addr, rd_data); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL guard_exit got %0b exp 0", pipe_stall); end
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h99)
      begin errors++; $display("FAIL guard_held got we=%0b a=%0d d=%08h exp we=1 a=9 d=99", rd_we, rd_addr, rd_data); end
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd9 || pipe_stall !== 1'b0)
        begin errors++; $display("FAIL noguard_blk%0d got we=%0b a=%0d stall=%0b exp we=1 a=9 stall=0", k, rd_we, rd_addr, pipe_stall); end
    end
    checks++; if (aux_pending !== 1'b1) begin errors++; $display("FAIL noguard_pending got %0b exp 1", aux_pending); end
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h33)
      begin errors++; $display("FAIL noguard_aux got we=%0b a=%0d d=%08h exp we=1 a=3 d=33", rd_we, rd_addr, rd_data); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL noguard_stall got %0b exp 0", pipe_stall); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      set_pipe(1'b1, 5'd20, 32'h200);
      set_aux(1'b1, 5'(1 + i), 32'hB0 + 32'(i));
      tick();
    end
    set_aux(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd1) begin errors++; $display("FAIL mid_drain got we=%0b a=%0d exp we=1 a=1", rd_we, rd_addr); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0)
      begin errors++; $display("FAIL mid_reset_out got we=%0b a=%0d d=%08h exp 0", rd_we, rd_addr, rd_data); end
    checks++; if (aux_ready !== 1'b1 || aux_pending !== 1'b0)
      begin errors++; $display("FAIL mid_reset_fifo got ready=%0b pending=%0b exp 1/0", aux_ready, aux_pending); end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (rd_we !== 1'b0 || aux_pending !== 1'b0)
        begin errors++; $display("FAIL post_reset%0d got we=%0b pending=%0b exp 0", k, rd_we, aux_pending); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_fifo_fill_drain();
    test_aux_x0();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
